// File: rtl/ext_bus_bridge_gen.sv
// ext_bus_bridge_gen: bridges a single CPU read/write request onto a
// multiplexed address/data external bus. The address is sent as one or more
// AD-width phases (lowest slice first), followed by a data phase that waits a
// programmable minimum time for ext_ready and aborts with an error on timeout.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a request; the only state where requests are sampled
// ADDR   | driving one AD-width address slice per cycle, ext_ae high
// DATA   | data phase; write data driven, waiting for qualified ext_ready
// DONE   | one-cycle cpu_ready pulse (cpu_err on timeout / illegal request)
//
// Every output is a register updated together with the state, so each
// output already holds its value for the state being entered.
module ext_bus_bridge_gen #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 8,
  parameter int AD_W     = 16,
  parameter int WAIT_MIN = 0,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_err,
  output logic              ext_rd,
  output logic              ext_wr,
  output logic              ext_ae,
  output logic              ext_doe,
  output logic [AD_W-1:0]   ext_ad_out,
  input  logic [DATA_W-1:0] ext_ad_in,
  input  logic              ext_ready
);

  localparam int NPH   = (ADDR_W + AD_W - 1) / AD_W;
  localparam int PAD_W = NPH * AD_W;
  localparam int PH_W  = (NPH > 1) ? $clog2(NPH) : 1;
  localparam int WMAX  = (WAIT_MIN > TIMEOUT) ? WAIT_MIN : TIMEOUT;
  localparam int CNT_W = $clog2(WMAX + 2);

  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(NPH - 1);
  localparam logic [CNT_W:0]   WMIN_C  = (CNT_W + 1)'(WAIT_MIN);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  if (DATA_W > AD_W) begin : g_bad_width
    $error("ext_bus_bridge_gen: DATA_W must not exceed AD_W");
  end

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

  state_t            state_q;
  logic [PH_W-1:0]   phase_q;
  logic [CNT_W-1:0]  wait_q;
  logic [PAD_W-1:0]  addr_sh_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              err_q;
  logic              ext_rd_q;
  logic              ext_wr_q;
  logic              ext_ae_q;
  logic              ext_doe_q;
  logic [AD_W-1:0]   ad_q;

  // Zero-extended request address, so a partial top slice reads as zeros.
  logic [PAD_W-1:0] cpu_addr_pad;
  assign cpu_addr_pad = PAD_W'(cpu_addr);

  // Wait-counter helpers: saturating next value, min-wait and timeout qualifiers.
  logic [CNT_W-1:0] wait_d;
  logic [CNT_W:0]   wait_inc;
  logic             wait_ok;
  logic             timeout_hit;
  always_comb begin
    wait_d      = (&wait_q) ? wait_q : wait_q + CNT_W'(1);
    wait_inc    = {1'b0, wait_q} + (CNT_W + 1)'(1);
    wait_ok     = wait_inc > WMIN_C;
    timeout_hit = TO_EN && (wait_q == TO_LAST);
  end

  // Bridge FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      wait_q    <= '0;
      addr_sh_q <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      ext_rd_q  <= 1'b0;
      ext_wr_q  <= 1'b0;
      ext_ae_q  <= 1'b0;
      ext_doe_q <= 1'b0;
      ad_q      <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cpu_rd ^ cpu_wr) begin
            // First slice goes out straight from the request; the rest are
            // kept in a shift register consumed one slice per ADDR cycle.
            addr_sh_q <= cpu_addr_pad >> AD_W;
            wdata_q   <= cpu_wdata;
            wr_q      <= cpu_wr;
            phase_q   <= '0;
            ext_rd_q  <= cpu_rd;
            ext_wr_q  <= cpu_wr;
            ext_ae_q  <= 1'b1;
            ad_q      <= cpu_addr_pad[AD_W-1:0];
            state_q   <= S_ADDR;
          end else if (cpu_rd && cpu_wr) begin
            ready_q <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_ADDR: begin
          if (phase_q == PH_LAST) begin
            wait_q    <= '0;
            ext_ae_q  <= 1'b0;
            ext_doe_q <= wr_q;
            ad_q      <= wr_q ? AD_W'(wdata_q) : '0;
            state_q   <= S_DATA;
          end else begin
            phase_q   <= phase_q + PH_W'(1);
            ad_q      <= addr_sh_q[AD_W-1:0];
            addr_sh_q <= addr_sh_q >> AD_W;
          end
        end
        S_DATA: begin
          // Ready takes priority over a timeout landing in the same cycle.
          if (wait_ok && ext_ready) begin
            if (!wr_q) rdata_q <= ext_ad_in;
            ready_q   <= 1'b1;
            ext_rd_q  <= 1'b0;
            ext_wr_q  <= 1'b0;
            ext_doe_q <= 1'b0;
            ad_q      <= '0;
            state_q   <= S_DONE;
          end else if (timeout_hit) begin
            ready_q   <= 1'b1;
            err_q     <= 1'b1;
            ext_rd_q  <= 1'b0;
            ext_wr_q  <= 1'b0;
            ext_doe_q <= 1'b0;
            ad_q      <= '0;
            state_q   <= S_DONE;
          end else begin
            wait_q <= wait_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_ready  = ready_q;
  assign cpu_err    = err_q;
  assign ext_rd     = ext_rd_q;
  assign ext_wr     = ext_wr_q;
  assign ext_ae     = ext_ae_q;
  assign ext_doe    = ext_doe_q;
  assign ext_ad_out = ad_q;

endmodule

// File: doc/ext_bus_bridge_gen.md
Name: ext_bus_bridge_gen

Overview:
- Parametrised successor to the single-byte external bus bridge.
- Bridges a CPU memory request (AFTAB side) onto a multiplexed address/data external chip bus.
- Address width, data width and external AD width are generic. Address phases are generated automatically, one phase per AD-width slice.
- Adds request capture, a programmable minimum wait, a ready timeout with error reporting, and a one-cycle completion pulse.

Parameters:
ADDR_W, 32, CPU address width.
DATA_W, 8, CPU/external data width; must be <= AD_W.
AD_W, 16, external multiplexed AD bus width.
WAIT_MIN, 0, DATA-state cycles before ext_ready is sampled.
TIMEOUT, 255, DATA-state cycles without ready before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-low reset.
cpu_rd  in  1  read request.
cpu_wr  in  1  write request.
cpu_addr  in  ADDR_W  request address.
cpu_wdata  in  DATA_W  write data.
cpu_rdata  out  DATA_W  registered read data.
cpu_ready  out  1  one-cycle completion pulse.
cpu_err  out  1  one-cycle error pulse, coincident with cpu_ready.
ext_rd  out  1  external read strobe.
ext_wr  out  1  external write strobe.
ext_ae  out  1  address-enable (address phase).
ext_doe  out  1  data-output-enable (write data phase).
ext_ad_out  out  AD_W  driven address/data.
ext_ad_in  in  DATA_W  read data from external bus.
ext_ready  in  1  external device ready.

Behaviour:
- NPH = ceil(ADDR_W/AD_W), the number of address phases.
- States: IDLE, ADDR, DATA, DONE. State register and phase/wait counters reset asynchronously when rst=0.
- Reset values: all outputs 0, cpu_rdata 0, state IDLE.
- Reset mid-transaction: outputs go to 0 immediately; no ready or error pulse is generated.
- IDLE:
  - Requests are sampled only in this state.
  - cpu_rd XOR cpu_wr: capture addr, wdata and op; phase=0; go to ADDR.
  - cpu_rd and cpu_wr both high: no bus cycle; go to DONE with cpu_err=1.
- ADDR:
  - ext_ae=1.
  - ext_ad_out = captured addr[phase*AD_W +: AD_W], lowest slice first. A partial top slice is zero-extended.
  - phase increments each cycle; after phase NPH-1, go to DATA and clear the wait counter.
- DATA:
  - ext_ae=0.
  - Write: ext_doe=1 and ext_ad_out = zero-extended wdata.
  - Read: ext_doe=0 and ext_ad_out=0.
  - The wait counter increments each cycle, saturating.
  - When wait count >= WAIT_MIN and ext_ready=1: on a read, latch ext_ad_in into cpu_rdata; go to DONE.
  - Else if TIMEOUT != 0 and wait count == TIMEOUT-1 with no qualifying ready: go to DONE with error flagged; cpu_rdata unchanged.
  - Ready and timeout in the same cycle: ready wins, no error.
- DONE:
  - cpu_ready=1 for exactly one cycle; cpu_err=1 if error was flagged. Then go to IDLE unconditionally.
  - ext_rd and ext_wr are 0 in this state.
- ext_rd / ext_wr: equal the captured op, asserted through ADDR and DATA; 0 in IDLE and DONE.
- Latency: request seen in IDLE at cycle 0 → ADDR at cycles 1..NPH → DATA from cycle NPH+1. With WAIT_MIN=0 and immediate ready, cpu_ready occurs at cycle NPH+2 (4 with defaults).
- Request hold: the CPU may drop its request after the IDLE sample. A request still high in the cycle after DONE starts a new transaction.
- ext_ready outside DATA is ignored.
- DATA_W > AD_W is illegal and flagged by an elaboration-time check.

Test Plan:
1. Reset and idle: rst=0 mid-ADDR → all outputs 0 immediately. After release, IDLE with no spurious cpu_ready.
2. Default-parameter write: addr=0x1234_5678, wdata=0xA5, ext_ready tied 1.
   - Cycle 1: ext_ad_out=0x5678, ext_ae=1.
   - Cycle 2: ext_ad_out=0x1234, ext_ae=1.
   - Cycle 3: ext_doe=1, ext_ad_out=0x00A5.
   - Cycle 4: cpu_ready=1, cpu_err=0.
3. Read with WAIT_MIN=3: ext_ready=1 from DATA cycle 0, ext_ad_in=0x3C → ready is ignored for the first 3 DATA cycles; cpu_rdata=0x3C; cpu_ready one cycle after the 4th DATA cycle.
4. Timeout with TIMEOUT=8 and ext_ready=0 → exactly 8 DATA cycles, then cpu_ready=1 and cpu_err=1; cpu_rdata keeps its previous value.
5. cpu_rd=cpu_wr=1 in IDLE → ext_rd, ext_wr and ext_ae stay 0; next cycle cpu_ready=1, cpu_err=1.
6. Parameter sweep ADDR_W=20, AD_W=8, DATA_W=8, addr=0xABCDE → three phases with AD values 0xDE, 0xBC, 0x0A; back-to-back held request starts its second transaction in the cycle after IDLE.
